train_step_ctrl: RTL and testbench
==================================

// Module: train_step_ctrl
// PURPOSE
//  Sequencer for one SGD training step of the 2-8-3 ReLU/softmax classifier.
//  Accepts a sample via valid/ready, starts the forward pass, then triggers backprop.
//  When the gradients are ready it pulses the weight write-back enable.
//  It also keeps per-epoch sample and correct-prediction counts.
//  Sits between the sample source and the forward/backprop datapaths; owns the weight-register write strobe.
// PARAMETERS
//  BP_LATENCY  3    cycles from first bp_trigger cycle until new W/b outputs are valid (>=1)
//  EPOCH_LEN   64   samples per epoch (>=2)
//  FWD_TIMEOUT 255  max cycles spent in FWD waiting for fwd_done (>=1)
//  CNT_W       8    width of sample/correct/epoch counters (2**CNT_W > EPOCH_LEN)
// PORTS
//  clk            in   1      clock, all state on rising edge
//  rst_n          in   1      asynchronous, active-low reset
//  train_en       in   1      level; 0 = accept no new samples (step in flight still completes)
//  sample_valid   in   1      source has inputs/realstate presented
//  sample_ready   out  1      controller accepts sample this cycle
//  fwd_start      out  1      1-cycle pulse: start forward pass
//  fwd_done       in   1      forward pass outputs (softmaxout, reluout, predictedstate) valid
//  predictedstate in   2      argmax of softmax, sampled with fwd_done
//  realstate      in   2      label 0..2, sampled with fwd_done; 3 = invalid
//  bp_trigger     out  1      held high for BP_LATENCY cycles to run backprop
//  wt_we          out  1      1-cycle pulse: load newW0/newb0/newW1/newb1 into weight regs
//  busy           out  1      1 whenever state != IDLE
//  epoch_done     out  1      1-cycle pulse, coincident with wt_we of last sample of epoch
//  sample_cnt     out  CNT_W  samples completed in current epoch
//  last_correct   out  CNT_W  correct predictions in the most recently finished epoch
//  epoch_cnt      out  CNT_W  epochs completed, wraps modulo 2**CNT_W
//  err_timeout    out  1      sticky: forward pass timed out
//  err_label      out  1      sticky: realstate==3 seen
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE. All outputs and internal counters are 0, including sticky errors.
//   wt_we/bp_trigger drop immediately, not at the next edge. A step in flight is discarded.
//  All outputs are registered except sample_ready and busy, which are decoded from state.
//  sample_ready = (state==IDLE) & train_en. Handshake = sample_valid & sample_ready.
//  FSM states: IDLE, FWD, BP, WB.
//  IDLE -> FWD on handshake. fwd_start=1 during the first FWD cycle only. FWD watchdog counter cleared.
//  FWD: fwd_done is sampled every FWD cycle, including the fwd_start cycle. fwd_done outside FWD is ignored.
//   fwd_done & realstate!=3: set hit=(predictedstate==realstate), go to BP.
//   fwd_done & realstate==3: set err_label, go to IDLE. No bp_trigger, no wt_we, no count change.
//   FWD_TIMEOUT cycles without fwd_done: set err_timeout, go to IDLE. No write, no count change.
//  BP: bp_trigger=1 for exactly BP_LATENCY consecutive cycles, then go to WB.
//  WB (1 cycle): wt_we=1. Accumulator correct_acc += hit.
//   If sample_cnt==EPOCH_LEN-1: epoch_done=1 and sample_cnt<=0.
//    last_correct<=correct_acc+hit; correct_acc<=0; epoch_cnt<=epoch_cnt+1 (wraps).
//   Otherwise: sample_cnt<=sample_cnt+1.
//   Go to IDLE.
//  Step latency from handshake: 1 (FWD entry) + fwd wait + BP_LATENCY + 1 (WB). Next handshake is possible the cycle after WB.
//  No back-to-back acceptance: throughput is at most 1 sample per (BP_LATENCY+3) cycles.
//  train_en falling mid-step: the step completes normally, then the FSM stays in IDLE with sample_ready=0.
//  Sticky errors clear only on reset. They do not block further training.
//  Never: two wt_we without an intervening handshake; bp_trigger outside BP; wt_we outside WB.
// TESTING
//  1. Reset, train_en=1, sample, fwd_done 2 cyc after fwd_start, pred=real=1 -> bp_trigger 3 cyc, wt_we 1 cyc, sample_cnt=1, busy 7 cyc.
//  2. 64 samples, 40 with pred==real -> epoch_done on 64th wt_we, last_correct=40, sample_cnt=0, epoch_cnt=1.
//  3. fwd_done high in the fwd_start cycle -> BP entered next cycle. Stray fwd_done in IDLE -> no effect.
//  4. fwd_done never asserted -> after 255 FWD cycles err_timeout=1, IDLE, no wt_we, sample_cnt unchanged.
//  5. realstate=3 at fwd_done -> err_label=1, no bp_trigger/wt_we. Next valid sample trains normally.
//  6. rst_n low during BP -> bp_trigger, counters and errors 0 immediately. Drop train_en mid-step -> wt_we still fires, then sample_ready=0.

Source files
------------

// File: rtl/train_step_ctrl.sv
// SGD step sequencer: sample handshake -> forward pass -> BP_LATENCY-cycle backprop -> 1-cycle weight write.
// Step latency 1 + fwd wait + BP_LATENCY + 1; sample_ready only in IDLE with train_en, so one sample is in flight at a time.
module train_step_ctrl #(
    parameter int BP_LATENCY  = 3,
    parameter int EPOCH_LEN   = 64,
    parameter int FWD_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             train_en,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             fwd_start,
    input  logic             fwd_done,
    input  logic [1:0]       predictedstate,
    input  logic [1:0]       realstate,
    output logic             bp_trigger,
    output logic             wt_we,
    output logic             busy,
    output logic             epoch_done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] last_correct,
    output logic [CNT_W-1:0] epoch_cnt,
    output logic             err_timeout,
    output logic             err_label
);

    localparam int MAXC = (FWD_TIMEOUT > BP_LATENCY) ? FWD_TIMEOUT : BP_LATENCY;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, FWD, BP, WB} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    step_q, step_d;
    logic             hit_q, hit_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_label_q, err_label_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] correct_acc_q, correct_acc_d;
    logic [CNT_W-1:0] last_correct_q, last_correct_d;
    logic [CNT_W-1:0] epoch_cnt_q, epoch_cnt_d;
    logic             fwd_start_q, fwd_start_d;
    logic             bp_trigger_q, bp_trigger_d;
    logic             wt_we_q, wt_we_d;
    logic             epoch_done_q, epoch_done_d;
    logic             handshake;
    logic             epoch_end;

    assign sample_ready = (state_q == IDLE) & train_en;
    assign busy         = (state_q != IDLE);
    assign handshake    = sample_valid & sample_ready;
    assign epoch_end    = (sample_cnt_q == CNT_W'(EPOCH_LEN - 1));

    always_comb begin
        state_d        = state_q;
        step_d         = step_q;
        hit_d          = hit_q;
        err_timeout_d  = err_timeout_q;
        err_label_d    = err_label_q;
        sample_cnt_d   = sample_cnt_q;
        correct_acc_d  = correct_acc_q;
        last_correct_d = last_correct_q;
        epoch_cnt_d    = epoch_cnt_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d = FWD;
                    step_d  = '0;
                end
            end
            FWD: begin
                // step_q doubles as the forward-pass watchdog here
                if (fwd_done) begin
                    if (realstate == 2'd3) begin
                        err_label_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        hit_d   = (predictedstate == realstate);
                        state_d = BP;
                        step_d  = '0;
                    end
                end else if (step_q == CW'(FWD_TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    step_d = step_q + CW'(1);
                end
            end
            BP: begin
                if (step_q == CW'(BP_LATENCY - 1)) begin
                    state_d = WB;
                end else begin
                    step_d = step_q + CW'(1);
                end
            end
            WB: begin
                state_d = IDLE;
                if (epoch_end) begin
                    sample_cnt_d   = '0;
                    last_correct_d = correct_acc_q + CNT_W'(hit_q);
                    correct_acc_d  = '0;
                    epoch_cnt_d    = epoch_cnt_q + CNT_W'(1);
                end else begin
                    sample_cnt_d  = sample_cnt_q + CNT_W'(1);
                    correct_acc_d = correct_acc_q + CNT_W'(hit_q);
                end
            end
            default: state_d = IDLE;
        endcase
        // strobes are registered copies of the state being entered
        fwd_start_d  = (state_q == IDLE) & handshake;
        bp_trigger_d = (state_d == BP);
        wt_we_d      = (state_d == WB);
        epoch_done_d = (state_d == WB) & epoch_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            step_q         <= '0;
            hit_q          <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_label_q    <= 1'b0;
            sample_cnt_q   <= '0;
            correct_acc_q  <= '0;
            last_correct_q <= '0;
            epoch_cnt_q    <= '0;
            fwd_start_q    <= 1'b0;
            bp_trigger_q   <= 1'b0;
            wt_we_q        <= 1'b0;
            epoch_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_q         <= step_d;
            hit_q          <= hit_d;
            err_timeout_q  <= err_timeout_d;
            err_label_q    <= err_label_d;
            sample_cnt_q   <= sample_cnt_d;
            correct_acc_q  <= correct_acc_d;
            last_correct_q <= last_correct_d;
            epoch_cnt_q    <= epoch_cnt_d;
            fwd_start_q    <= fwd_start_d;
            bp_trigger_q   <= bp_trigger_d;
            wt_we_q        <= wt_we_d;
            epoch_done_q   <= epoch_done_d;
        end
    end

    assign fwd_start    = fwd_start_q;
    assign bp_trigger   = bp_trigger_q;
    assign wt_we        = wt_we_q;
    assign epoch_done   = epoch_done_q;
    assign sample_cnt   = sample_cnt_q;
    assign last_correct = last_correct_q;
    assign epoch_cnt    = epoch_cnt_q;
    assign err_timeout  = err_timeout_q;
    assign err_label    = err_label_q;

endmodule

// File: tb/tb_train_step_ctrl.sv
// Directed bench for train_step_ctrl: a step-timeline model is compared every cycle, plus literal checkpoints.
module tb_train_step_ctrl;

    localparam int BPL = 3;
    localparam int EL  = 64;
    localparam int FT  = 255;
    localparam int CW  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          train_en = 1'b0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic          fwd_start;
    logic          fwd_done = 1'b0;
    logic [1:0]    predictedstate = 2'd0;
    logic [1:0]    realstate = 2'd0;
    logic          bp_trigger;
    logic          wt_we;
    logic          busy;
    logic          epoch_done;
    logic [CW-1:0] sample_cnt;
    logic [CW-1:0] last_correct;
    logic [CW-1:0] epoch_cnt;
    logic          err_timeout;
    logic          err_label;

    int n_chk = 0;
    int n_fail = 0;
    int busy_cycles = 0;
    int bp_cycles = 0;
    int we_cycles = 0;

    always #5 clk = ~clk;

    train_step_ctrl #(.BP_LATENCY(BPL), .EPOCH_LEN(EL), .FWD_TIMEOUT(FT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .train_en(train_en), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .fwd_start(fwd_start), .fwd_done(fwd_done),
        .predictedstate(predictedstate), .realstate(realstate), .bp_trigger(bp_trigger),
        .wt_we(wt_we), .busy(busy), .epoch_done(epoch_done), .sample_cnt(sample_cnt),
        .last_correct(last_correct), .epoch_cnt(epoch_cnt), .err_timeout(err_timeout),
        .err_label(err_label)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: where the current step is on its timeline, counted from the first FWD cycle.
    int m_busy = 0, m_t = 0, m_done_at = -1, m_hit = 0;
    int m_total = 0, m_ep_hits = 0, m_last = 0, m_et = 0, m_el = 0;

    always @(negedge clk) begin
        bit e_wt;
        bit e_bp;
        if (!rst_n) begin
            m_busy = 0; m_t = 0; m_done_at = -1; m_hit = 0;
            m_total = 0; m_ep_hits = 0; m_last = 0; m_et = 0; m_el = 0;
        end
        e_wt = (m_busy != 0) && (m_done_at >= 0) && (m_t == m_done_at + BPL + 1);
        e_bp = (m_busy != 0) && (m_done_at >= 0) && (m_t > m_done_at) && (m_t <= m_done_at + BPL);
        chk("sample_ready", sample_ready, 32'((m_busy == 0) && train_en));
        chk("busy", busy, 32'(m_busy != 0));
        chk("fwd_start", fwd_start, 32'((m_busy != 0) && (m_t == 0)));
        chk("bp_trigger", bp_trigger, 32'(e_bp));
        chk("wt_we", wt_we, 32'(e_wt));
        chk("epoch_done", epoch_done, 32'(e_wt && (m_total % EL == EL - 1)));
        chk("sample_cnt", sample_cnt, 32'(m_total % EL));
        chk("epoch_cnt", epoch_cnt, 32'((m_total / EL) % 256));
        chk("last_correct", last_correct, 32'(m_last));
        chk("err_timeout", err_timeout, 32'(m_et));
        chk("err_label", err_label, 32'(m_el));
        if (busy) busy_cycles++;
        if (bp_trigger) bp_cycles++;
        if (wt_we) we_cycles++;
        if (rst_n) begin
            if (m_busy == 0) begin
                if (sample_valid && train_en) begin
                    m_busy = 1; m_t = 0; m_done_at = -1;
                end
            end else if (m_done_at < 0) begin
                if (fwd_done) begin
                    if (realstate == 2'd3) begin
                        m_el = 1; m_busy = 0;
                    end else begin
                        m_done_at = m_t; m_hit = (predictedstate == realstate) ? 1 : 0; m_t++;
                    end
                end else if (m_t == FT - 1) begin
                    m_et = 1; m_busy = 0;
                end else begin
                    m_t++;
                end
            end else if (e_wt) begin
                m_total++;
                m_ep_hits += m_hit;
                if (m_total % EL == 0) begin
                    m_last = m_ep_hits; m_ep_hits = 0;
                end
                m_busy = 0;
            end else begin
                m_t++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin tick(); n++; end
        if (busy) chk("wait_idle_bound", 32'(busy), 32'd0);
    endtask

    // give=0 withholds fwd_done so the watchdog fires
    task automatic run_sample(input logic [1:0] p, input logic [1:0] r, input int dly, input bit give);
        int n = 0;
        sample_valid = 1'b1;
        while (!sample_ready && n < 50) begin tick(); n++; end
        if (!sample_ready) chk("handshake_bound", 32'(sample_ready), 32'd1);
        tick();
        sample_valid = 1'b0;
        if (give) begin
            repeat (dly) tick();
            fwd_done = 1'b1; predictedstate = p; realstate = r;
            tick();
            fwd_done = 1'b0;
        end
        wait_idle(FT + 20);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [1:0] r;
        repeat (2) tick();
        chk("rst_sample_cnt", 32'(sample_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wt_we", 32'(wt_we), 32'd0);
        rst_n = 1'b1;
        train_en = 1'b1;
        tick();

        // 1: single step, fwd_done two cycles after fwd_start
        busy_cycles = 0; bp_cycles = 0; we_cycles = 0;
        run_sample(2'd1, 2'd1, 2, 1'b1);
        chk("t1_sample_cnt", 32'(sample_cnt), 32'd1);
        chk("t1_busy_cycles", 32'(busy_cycles), 32'd7);
        chk("t1_bp_cycles", 32'(bp_cycles), 32'd3);
        chk("t1_we_cycles", 32'(we_cycles), 32'd1);

        // 2: full epoch, 40 of 64 correct
        do_reset();
        for (int i = 0; i < EL; i++) begin
            r = 2'(i % 3);
            run_sample((i < 40) ? r : 2'((i + 1) % 3), r, i % 4, 1'b1);
        end
        chk("t2_last_correct", 32'(last_correct), 32'd40);
        chk("t2_sample_cnt", 32'(sample_cnt), 32'd0);
        chk("t2_epoch_cnt", 32'(epoch_cnt), 32'd1);

        // 3: fwd_done in the fwd_start cycle, then stray fwd_done while idle
        run_sample(2'd2, 2'd0, 0, 1'b1);
        chk("t3_sample_cnt", 32'(sample_cnt), 32'd1);
        fwd_done = 1'b1; realstate = 2'd3;
        repeat (3) tick();
        fwd_done = 1'b0;
        chk("t3_stray_busy", 32'(busy), 32'd0);
        chk("t3_stray_err_label", 32'(err_label), 32'd0);

        // 4: forward pass never completes
        run_sample(2'd0, 2'd0, 0, 1'b0);
        chk("t4_err_timeout", 32'(err_timeout), 32'd1);
        chk("t4_sample_cnt", 32'(sample_cnt), 32'd1);

        // 5: invalid label, then a normal sample
        run_sample(2'd0, 2'd3, 1, 1'b1);
        chk("t5_err_label", 32'(err_label), 32'd1);
        chk("t5_sample_cnt", 32'(sample_cnt), 32'd1);
        run_sample(2'd0, 2'd0, 1, 1'b1);
        chk("t5_next_sample_cnt", 32'(sample_cnt), 32'd2);

        // 6a: train_en drops mid-step
        sample_valid = 1'b1;
        tick();
        train_en = 1'b0;
        fwd_done = 1'b1; predictedstate = 2'd1; realstate = 2'd1;
        tick();
        fwd_done = 1'b0;
        wait_idle(50);
        chk("t6_sample_cnt", 32'(sample_cnt), 32'd3);
        repeat (4) tick();
        chk("t6_ready_low", 32'(sample_ready), 32'd0);
        chk("t6_stays_idle", 32'(busy), 32'd0);
        sample_valid = 1'b0;
        train_en = 1'b1;
        tick();

        // 6b: reset during BP
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        fwd_done = 1'b1; predictedstate = 2'd2; realstate = 2'd2;
        tick();
        fwd_done = 1'b0;
        chk("t6_in_bp", 32'(bp_trigger), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_bp_trigger", 32'(bp_trigger), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_sample_cnt", 32'(sample_cnt), 32'd0);
        chk("t6_rst_epoch_cnt", 32'(epoch_cnt), 32'd0);
        chk("t6_rst_err_timeout", 32'(err_timeout), 32'd0);
        chk("t6_rst_err_label", 32'(err_label), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("t6_post_rst_we", 32'(wt_we), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
